// File: rtl/except_pkg.sv
// Shared constants for the machine interrupt path: cause bit positions,
// register-port select encodings and the mtimecmp reset value.
package except_pkg;

    localparam int MSI = 3;
    localparam int MTI = 7;
    localparam int MEI = 11;

    localparam logic [1:0] SEL_MSIP     = 2'd0;
    localparam logic [1:0] SEL_MTIMECMP = 2'd1;
    localparam logic [1:0] SEL_MTIME    = 2'd2;
    localparam logic [1:0] SEL_RSVD     = 2'd3;

    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/interrupt_source_sync2.sv
// Generic two-flop synchronizer for a single asynchronous level input,
// synchronous active-low reset.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/interrupt_source.sv
// Machine interrupt source: mtime/mtimecmp timer with prescaler, msip bit and
// synchronized external line, feeding a registered pending vector.
module interrupt_source
    import except_pkg::*;
#(
    parameter int N        = 64,
    parameter int PRESCALE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ext_irq,
    input  logic         MIE,
    input  logic [15:0]  mie,
    input  logic [1:0]   reg_sel,
    input  logic         reg_we,
    input  logic [N-1:0] reg_wdata,
    output logic [N-1:0] reg_rdata,
    output logic [15:0]  interruptSignal,
    output logic         async
);

    localparam logic [7:0] PS_LAST = 8'(PRESCALE - 1);

    logic [7:0]   prescaler;
    logic [N-1:0] mtime;
    logic [N-1:0] mtimecmp;
    logic         msip;
    logic         ext_sync;
    logic [15:0]  pend_nxt;
    logic         mtime_wr;

    sync2 u_ext_sync (
        .clk   (clk),
        .reset (reset),
        .d     (ext_irq),
        .q     (ext_sync)
    );

    assign mtime_wr = reg_we && (reg_sel == SEL_MTIME);

    // Pending bits are formed from pre-edge state, so a register write shows
    // up one edge after the write edge has updated the register.
    always_comb begin
        pend_nxt      = '0;
        pend_nxt[MSI] = msip;
        pend_nxt[MTI] = (mtime >= mtimecmp);
        pend_nxt[MEI] = ext_sync;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mtime           <= '0;
            prescaler       <= '0;
            mtimecmp        <= N'(MTIMECMP_RESET);
            msip            <= 1'b0;
            interruptSignal <= '0;
        end else begin
            // A software write to mtime wins over a tick and restarts the phase.
            if (mtime_wr) begin
                mtime     <= reg_wdata;
                prescaler <= '0;
            end else if (prescaler == PS_LAST) begin
                mtime     <= mtime + N'(1);
                prescaler <= '0;
            end else begin
                prescaler <= prescaler + 8'd1;
            end
            if (reg_we && (reg_sel == SEL_MTIMECMP))
                mtimecmp <= reg_wdata;
            if (reg_we && (reg_sel == SEL_MSIP))
                msip <= reg_wdata[0];
            interruptSignal <= pend_nxt;
        end
    end

    always_comb begin
        reg_rdata = '0;
        case (reg_sel)
            SEL_MSIP:     reg_rdata = {{(N-1){1'b0}}, msip};
            SEL_MTIMECMP: reg_rdata = mtimecmp;
            SEL_MTIME:    reg_rdata = mtime;
            SEL_RSVD:     reg_rdata = '0;
            default:      reg_rdata = '0;
        endcase
    end

    assign async = MIE & (|(interruptSignal & mie));

endmodule
